// File: rtl/seg7_pkg.sv
// seg7_pkg: shared display-scheduler state encoding and default error glyph
package seg7_pkg;
    typedef enum logic [1:0] {BLANK, MEAS, MSG, ERR} disp_state_t;
    localparam logic [15:0] ERR_PATTERN_DFLT = 16'hEEEE;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle pulse every millisecond of clk
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_ms
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    logic [PW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick_ms = cnt_q == LAST;
        cnt_d = tick_ms ? '0 : cnt_q + PW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seg7_disp_sched.sv
// seg7_disp_sched: arbitrates the display between error, timed banner and rate-limited measurement
module seg7_disp_sched
    import seg7_pkg::*;
#(
    parameter int          CLK_HZ      = 100_000_000,
    parameter int          MSG_HOLD_MS = 1500,
    parameter int          UPD_MS      = 250,
    parameter logic [15:0] ERR_PATTERN = ERR_PATTERN_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        meas_valid,
    input  logic [15:0] meas_x,
    input  logic [3:0]  meas_dp,
    input  logic        msg_req,
    input  logic [15:0] msg_x,
    input  logic [3:0]  msg_dp,
    output logic        msg_ack,
    output logic        msg_done,
    output logic        msg_abort,
    input  logic        err,
    output logic [15:0] disp_x,
    output logic [3:0]  disp_dp,
    output logic        disp_en,
    output logic [1:0]  state_o
);
    localparam int CMAX = MSG_HOLD_MS > UPD_MS ? MSG_HOLD_MS : UPD_MS;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_END = CW'(MSG_HOLD_MS);
    localparam logic [CW-1:0] UPD_END = CW'(UPD_MS);

    logic tick, in_msg, copy;
    disp_state_t state_q, state_d;
    logic [CW-1:0] hold_q, hold_d, hold_n, upd_q, upd_d, upd_n;
    logic [15:0] shadow_x_q, shadow_x_d, last_x_q, last_x_d, disp_x_q, disp_x_d;
    logic [3:0] shadow_dp_q, shadow_dp_d, last_dp_q, last_dp_d, disp_dp_q, disp_dp_d;
    logic fresh_q, fresh_d, ack_q, ack_d, done_q, done_d, abort_q, abort_d, disp_en_q, disp_en_d;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst(rst), .tick_ms(tick));

    always_comb begin
        hold_n = hold_q == HOLD_END ? hold_q : hold_q + CW'(tick);
        upd_n = upd_q == UPD_END ? upd_q : upd_q + CW'(tick);
        in_msg = state_q == MSG;
        ack_d = 1'b0;
        done_d = 1'b0;
        abort_d = 1'b0;
        if (!en || err) begin
            state_d = en ? ERR : BLANK;
            done_d = in_msg;
            abort_d = in_msg;
        end else if (in_msg) begin
            state_d = hold_n == HOLD_END ? MEAS : MSG;
            done_d = hold_n == HOLD_END;
        end else if (msg_req) begin
            state_d = MSG;
            ack_d = 1'b1;
        end else begin
            state_d = MEAS;
        end
        // Entry into MEAS shows a fresh sample at once; afterwards only once per update interval
        copy = state_d == MEAS && fresh_q && (state_q != MEAS || upd_n == UPD_END);
        upd_d = (state_q != MEAS || copy) ? '0 : upd_n;
        hold_d = ack_d ? '0 : in_msg ? hold_n : hold_q;
        shadow_x_d = meas_valid ? meas_x : shadow_x_q;
        shadow_dp_d = meas_valid ? meas_dp : shadow_dp_q;
        fresh_d = meas_valid | (fresh_q & ~copy);
        last_x_d = copy ? shadow_x_q : last_x_q;
        last_dp_d = copy ? shadow_dp_q : last_dp_q;
        disp_x_d = state_d == MEAS ? last_x_d :
                   state_d == MSG  ? (ack_d ? msg_x : disp_x_q) :
                   state_d == ERR  ? ERR_PATTERN : '0;
        disp_dp_d = state_d == MEAS ? last_dp_d :
                    state_d == MSG  ? (ack_d ? msg_dp : disp_dp_q) : '0;
        disp_en_d = state_d != BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            hold_q <= '0;
            upd_q <= '0;
            shadow_x_q <= '0;
            shadow_dp_q <= '0;
            fresh_q <= 1'b0;
            last_x_q <= '0;
            last_dp_q <= '0;
            disp_x_q <= '0;
            disp_dp_q <= '0;
            disp_en_q <= 1'b0;
            ack_q <= 1'b0;
            done_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            upd_q <= upd_d;
            shadow_x_q <= shadow_x_d;
            shadow_dp_q <= shadow_dp_d;
            fresh_q <= fresh_d;
            last_x_q <= last_x_d;
            last_dp_q <= last_dp_d;
            disp_x_q <= disp_x_d;
            disp_dp_q <= disp_dp_d;
            disp_en_q <= disp_en_d;
            ack_q <= ack_d;
            done_q <= done_d;
            abort_q <= abort_d;
        end
    end

    assign disp_x = disp_x_q;
    assign disp_dp = disp_dp_q;
    assign disp_en = disp_en_q;
    assign msg_ack = ack_q;
    assign msg_done = done_q;
    assign msg_abort = abort_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_seg7_disp_sched.sv
// tb_seg7_disp_sched: scenario tasks checked against a countdown/age-based display model
module tb_seg7_disp_sched;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, meas_valid = 1'b0, msg_req = 1'b0, err = 1'b0;
    logic [15:0] meas_x = '0, msg_x = '0, disp_x;
    logic [3:0] meas_dp = '0, msg_dp = '0, disp_dp;
    logic msg_ack, msg_done, msg_abort, disp_en;
    logic [1:0] state_o;
    int total = 0, passed = 0;

    int m_st, m_left, m_age;
    logic [15:0] m_sx, m_lx, m_bx;
    logic [3:0] m_sdp, m_ldp, m_bdp;
    logic m_fresh, e_ack, e_done, e_abort;
    logic [25:0] obs, expv;

    seg7_disp_sched #(.CLK_HZ(1000), .MSG_HOLD_MS(5), .UPD_MS(3)) dut (
        .clk(clk), .rst(rst), .en(en), .meas_valid(meas_valid), .meas_x(meas_x), .meas_dp(meas_dp),
        .msg_req(msg_req), .msg_x(msg_x), .msg_dp(msg_dp), .msg_ack(msg_ack), .msg_done(msg_done),
        .msg_abort(msg_abort), .err(err), .disp_x(disp_x), .disp_dp(disp_dp), .disp_en(disp_en),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {disp_x, disp_dp, disp_en, state_o, msg_ack, msg_done, msg_abort};
    assign expv = {m_st == 1 ? m_lx : m_st == 2 ? m_bx : m_st == 3 ? 16'hEEEE : 16'h0000,
                   m_st == 1 ? m_ldp : m_st == 2 ? m_bdp : 4'h0,
                   m_st != 0, 2'(m_st), e_ack, e_done, e_abort};

    // States: 0 blank, 1 meas, 2 banner, 3 error; tick assumed every cycle (CLK_HZ=1000)
    task automatic model_step();
        int ns;
        e_ack = 0; e_done = 0; e_abort = 0;
        if (rst) begin
            m_st = 0; m_left = 0; m_age = 0; m_fresh = 0;
            m_sx = 0; m_sdp = 0; m_lx = 0; m_ldp = 0; m_bx = 0; m_bdp = 0;
            return;
        end
        if (!en || err) begin
            ns = en ? 3 : 0;
            e_done = m_st == 2;
            e_abort = m_st == 2;
        end else if (m_st == 2) begin
            m_left--;
            ns = m_left == 0 ? 1 : 2;
            e_done = m_left == 0;
        end else if (msg_req) begin
            ns = 2; e_ack = 1; m_left = 5; m_bx = msg_x; m_bdp = msg_dp;
        end else begin
            ns = 1;
        end
        if (ns == 1) begin
            m_age = m_st == 1 ? m_age + 1 : 0;
            if (m_fresh && (m_st != 1 || m_age >= 3)) begin
                m_lx = m_sx; m_ldp = m_sdp; m_fresh = 0; m_age = 0;
            end
        end
        if (meas_valid) begin
            m_sx = meas_x; m_sdp = meas_dp; m_fresh = 1;
        end
        m_st = ns;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0;
        repeat (3) tick();
        total++;
        if (obs !== expv || obs !== 26'h0) $display("FAIL reset obs=%h exp=%h", obs, expv);
        else passed++;
        rst = 0;
    endtask

    task automatic test_meas_basic();
        meas_valid = 1; meas_x = 16'h1234; meas_dp = 4'b0100;
        tick();
        meas_valid = 0; en = 1;
        tick();
        total++;
        if (obs !== expv || disp_x !== 16'h1234 || disp_dp !== 4'b0100 || disp_en !== 1'b1)
            $display("FAIL meas_basic obs=%h exp=%h", obs, expv);
        else passed++;
    endtask

    task automatic test_rate_limit();
        int changes = 0;
        logic [15:0] prev;
        prev = disp_x;
        for (int i = 0; i < 18; i++) begin
            meas_valid = 1; meas_x = 16'h0100 + 16'(i); meas_dp = 4'(i);
            tick();
            if (disp_x !== prev) changes++;
            prev = disp_x;
            total++;
            if (obs !== expv) $display("FAIL rate_limit[%0d] obs=%h exp=%h", i, obs, expv);
            else passed++;
        end
        meas_valid = 0;
        total++;
        if (changes !== 6) $display("FAIL rate_changes got=%0d want=6", changes);
        else passed++;
    endtask

    task automatic test_msg();
        int in_msg = 0;
        msg_req = 1; msg_x = 16'hA5C0; msg_dp = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (e_ack) msg_req = 0;
            if (state_o == 2'd2) begin
                in_msg++;
                total++;
                if (disp_x !== 16'hA5C0) $display("FAIL msg_value got=%h want=a5c0", disp_x);
                else passed++;
            end
            total++;
            if (obs !== expv) $display("FAIL msg[%0d] obs=%h exp=%h", i, obs, expv);
            else passed++;
        end
        total++;
        if (in_msg !== 5) $display("FAIL msg_hold got=%0d want=5", in_msg);
        else passed++;
    endtask

    task automatic test_err_abort();
        msg_req = 1; msg_x = 16'hC0DE; msg_dp = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            err = i >= 2 && i < 6;
            meas_valid = i == 4; meas_x = 16'h0777; meas_dp = 4'b0010;
            tick();
            if (e_ack) msg_req = 0;
            total++;
            if (obs !== expv || (i == 2 && {msg_done, msg_abort, disp_x} !== {2'b11, 16'hEEEE}))
                $display("FAIL err_abort[%0d] obs=%h exp=%h", i, obs, expv);
            else passed++;
        end
        meas_valid = 0; err = 0;
    endtask

    task automatic test_pending_err();
        err = 1; msg_req = 1; msg_x = 16'hBEEF; msg_dp = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) err = 0;
            if (i == 6) en = 0;
            tick();
            if (e_ack) msg_req = 0;
            total++;
            if (obs !== expv) $display("FAIL pending_err[%0d] obs=%h exp=%h", i, obs, expv);
            else passed++;
        end
        en = 1;
    endtask

    task automatic test_reset_mid_msg();
        tick();
        msg_req = 1; msg_x = 16'h1357; msg_dp = 4'b0110;
        tick();
        msg_req = 0;
        tick();
        rst = 1;
        tick();
        total++;
        if (obs !== expv || disp_en !== 1'b0 || msg_done !== 1'b0)
            $display("FAIL reset_mid_msg obs=%h exp=%h", obs, expv);
        else passed++;
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 19) != 0;
            err = err ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 24) == 0);
            meas_valid = $urandom_range(0, 2) == 0;
            meas_x = 16'($urandom);
            meas_dp = 4'($urandom);
            if (!msg_req && $urandom_range(0, 9) == 0) begin
                msg_req = 1; msg_x = 16'($urandom); msg_dp = 4'($urandom);
            end
            tick();
            if (e_ack) msg_req = 0;
            total++;
            if (obs !== expv) $display("FAIL random[%0d] obs=%h exp=%h", i, obs, expv);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_meas_basic();
        test_rate_limit();
        test_msg();
        test_err_abort();
        test_pending_err();
        test_reset_mid_msg();
        en = 1;
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
